des_key_schedule: RTL
=====================

// Module: des_key_schedule
// PURPOSE
//  DES round-key generator; sits downstream of key_split_28 and consumes its 28-bit C/D halves.
//  Accepts one 56-bit PC-1-permuted key and produces the 16 48-bit round subkeys, one per handshake.
//  Subkeys come from per-round left rotations of C/D followed by PC-2.
//  Output goes to the Feistel round engine.
// PARAMETERS
//  KEY_W   56  width of PC-1 key input (fixed by DES; elaborate-time check == 56)
//  SUB_W   48  width of subkey output (fixed by DES; check == 48)
//  ROUNDS  16  subkeys emitted per key (fixed; check == 16)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   asynchronous active-high reset
//  key_in       in   56  PC-1-permuted key; split internally into C=key_in[55:28], D=key_in[27:0]
//  key_valid    in   1   key_in valid
//  key_ready    out  1   high only in IDLE; key accepted when key_valid & key_ready
//  decrypt      in   1   sampled with key; 1 = emit K16..K1
//  subkey       out  48  current round key, PC-2(C_r,D_r)
//  subkey_valid out  1   subkey valid
//  subkey_ready in   1   consumer accepts when subkey_valid & subkey_ready
//  round_idx    out  4   index of the presented subkey (0..15, emission order)
//  subkey_last  out  1   high with the 16th subkey
// BEHAVIOUR
//  Reset: state=IDLE, key_ready=1, subkey_valid=0, subkey=0, round_idx=0, subkey_last=0, C/D regs=0.
//  FSM states:
//   IDLE: on key accept, latch C,D and mode, set r=0, go to ROUND.
//   ROUND: compute next C/D, register subkey, assert subkey_valid, go to HOLD.
//   HOLD: on subkey accept, either r<15 -> r++ and go to ROUND, or r==15 -> go to IDLE.
//  Latency: first subkey_valid 2 cycles after key accept; then 1 bubble cycle between subkeys
//   (full schedule >= 32 cycles).
//  Shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
//  Encrypt, emission r=0..15: C,D = rotl28(C,D, s[r+1]); subkey = K_{r+1}.
//  Decrypt, emission r=0: no rotation (C16==C0), subkey = K16.
//   r>=1: C,D = rotr28(C,D, s[17-r]); subkey = K_{16-r}.
//  Rotation is modulo 28 on each half independently; C and D never mix before PC-2.
//  PC-2 selects 48 of 56 bits of {C,D}; bits 9,18,22,25,35,38,43,54 (1-based, MSB=1) are dropped.
//  subkey_ready low in HOLD: subkey, round_idx, subkey_last hold stable; subkey_valid stays 1.
//  key_valid while not IDLE: ignored (key_ready=0); no queuing.
//  Last subkey accept: goes to IDLE; key_ready=1 the next cycle. A new key may be accepted that cycle.
//  rst asserted mid-schedule: immediate return to reset values; the partial schedule is discarded.
//  After a full encrypt run C/D equal the loaded C0/D0 (sum of shifts = 28); required invariant.
// CONFIGURATION
//  DES_DECRYPT_EN defined: decrypt port is honoured as above.
//  DES_DECRYPT_EN undefined: decrypt is ignored; the mode latch and rotr path are not built;
//   the block is encrypt-only.
// STRUCTURE
//  des_pkg holds:
//   - SHIFT_TABLE[16]
//   - PC2 index table
//   - FSM state encoding (IDLE/ROUND/HOLD)
//   - KEY_W/SUB_W/ROUNDS constants
//  Submodules:
//   - key_split_28: splits key_in.
//   - des_pc2: purely combinational 56->48 permutation, reused by the test model.
// TESTING
//  1 Key 133457799BBCDFF1, post-PC-1 key_in=F0CCAAF556678F, encrypt, subkey_ready=1 ->
//    first subkey 1B02EFFC7072 (idx0), second 79AED9DBC9E5, 16th CB3D8B0E17F5 with subkey_last=1.
//  2 Same key, decrypt=1 (DES_DECRYPT_EN) -> first CB3D8B0E17F5, last 1B02EFFC7072;
//    full sequence is the reverse of scenario 1.
//  3 Backpressure: subkey_ready low 5 cycles at idx3 -> subkey/round_idx stable, valid held,
//    sequence unchanged afterward.
//  4 key_valid held high during schedule with different key_in -> ignored.
//    key_ready=1 only after idx15 accept; second key accepted that cycle.
//  5 rst pulsed while idx7 presented -> all outputs to reset values next edge.
//    New key after release yields full correct 16-key sequence.
//  6 Random keys x1000 vs. reference model; check C/D==C0/D0 after each encrypt run.

Source files
------------

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants for the DES key schedule:
//   - key/subkey/round widths
//   - per-round left-rotation amounts (SHIFT_TABLE)
//   - PC-2 selection table (1-based bit numbers of {C,D}, MSB = bit 1)
//   - FSM state encoding
//   - 28-bit rotate helpers used by the schedule datapath
// Optional feature macro used by the consumers of this package: DES_DECRYPT_EN
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int DES_KEY_W  = 56;
    localparam int DES_SUB_W  = 48;
    localparam int DES_ROUNDS = 16;
    localparam int HALF_W     = 28;

    localparam logic [3:0] LAST_ROUND = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_HOLD  = 2'd2
    } des_state_e;

    // Left-rotation amount applied before K1..K16 (index 0 -> K1).
    localparam logic [1:0] SHIFT_TABLE [DES_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC-2: subkey bit i (1-based from MSB) is {C,D} bit PC2_TABLE[i-1].
    localparam int PC2_TABLE [DES_SUB_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Rotate a 28-bit half left by 0..2 positions.
    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
        case (n)
            2'd1:    rotl28 = {x[HALF_W-2:0], x[HALF_W-1]};
            2'd2:    rotl28 = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            default: rotl28 = x;
        endcase
    endfunction

    // Rotate a 28-bit half right by 0..2 positions.
    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
        case (n)
            2'd1:    rotr28 = {x[0], x[HALF_W-1:1]};
            2'd2:    rotr28 = {x[1:0], x[HALF_W-1:2]};
            default: rotr28 = x;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Purely combinational PC-2 permutation: selects 48 of the 56 bits of {C,D}.
//   cd      in  56  {C,D}, bit 1 (1-based) = cd[55]
//   subkey  out 48  permuted round key, bit 1 (1-based) = subkey[47]
// -----------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [DES_KEY_W-1:0] cd,
    output logic [DES_SUB_W-1:0] subkey
);

    // Bits 9,18,22,25,35,38,43,54 (1-based) are not selected by PC-2.
    logic unused_dropped_s;
    assign unused_dropped_s = ^{cd[47], cd[38], cd[34], cd[31],
                                cd[21], cd[18], cd[13], cd[2]};

    for (genvar i = 0; i < DES_SUB_W; i++) begin : g_sel
        assign subkey[DES_SUB_W-1-i] = cd[DES_KEY_W - PC2_TABLE[i]];
    end

endmodule

// File: rtl/key_split_28.sv
// -----------------------------------------------------------------------------
// key_split_28
// Splits the PC-1-permuted 56-bit key into its 28-bit C (upper) and D (lower)
// halves.
//   key_in  in  56  PC-1-permuted key
//   c_half  out 28  key_in[55:28]
//   d_half  out 28  key_in[27:0]
// -----------------------------------------------------------------------------
module key_split_28
    import des_pkg::*;
(
    input  logic [DES_KEY_W-1:0] key_in,
    output logic [HALF_W-1:0]    c_half,
    output logic [HALF_W-1:0]    d_half
);

    assign c_half = key_in[DES_KEY_W-1:HALF_W];
    assign d_half = key_in[HALF_W-1:0];

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// DES round-key generator. Accepts one PC-1-permuted key per handshake and
// emits the 16 PC-2 round subkeys, one per subkey handshake, with one bubble
// cycle between subkeys.
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   key_in       in   56  PC-1-permuted key (C = [55:28], D = [27:0])
//   key_valid    in   1   key_in valid
//   key_ready    out  1   high only when idle
//   decrypt      in   1   sampled with the key; 1 = emit K16..K1
//   subkey       out  48  current round key
//   subkey_valid out  1   subkey valid
//   subkey_ready in   1   consumer ready
//   round_idx    out  4   emission index 0..15
//   subkey_last  out  1   high with the 16th subkey
// Configuration macro: DES_DECRYPT_EN (defined: decrypt honoured; undefined:
// encrypt-only, decrypt ignored and the reverse-rotation path is not built).
// -----------------------------------------------------------------------------
module des_key_schedule #(
    parameter int KEY_W  = 56,
    parameter int SUB_W  = 48,
    parameter int ROUNDS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             decrypt,
    output logic [SUB_W-1:0] subkey,
    output logic             subkey_valid,
    input  logic             subkey_ready,
    output logic [3:0]       round_idx,
    output logic             subkey_last
);
    import des_pkg::*;

    if (KEY_W != DES_KEY_W || SUB_W != DES_SUB_W || ROUNDS != DES_ROUNDS) begin : g_bad_param
        $error("des_key_schedule: KEY_W/SUB_W/ROUNDS are fixed at 56/48/16");
    end

    des_state_e           state_r;
    des_state_e           state_nxt_s;
    logic [HALF_W-1:0]    c_r, d_r;
    logic [HALF_W-1:0]    c_nxt_s, d_nxt_s;
    logic [HALF_W-1:0]    c_load_s, d_load_s;
    logic [HALF_W-1:0]    c_rot_s, d_rot_s;
    logic [1:0]           amt_s;
    logic [3:0]           round_idx_r, round_idx_nxt_s;
    logic [DES_SUB_W-1:0] pc2_s;
    logic [DES_SUB_W-1:0] subkey_r, subkey_nxt_s;
    logic                 subkey_valid_r, subkey_last_r, key_ready_r;
    logic                 dec_r, dec_nxt_s;

    key_split_28 u_split (
        .key_in (key_in),
        .c_half (c_load_s),
        .d_half (d_load_s)
    );

    des_pc2 u_pc2 (
        .cd     ({c_rot_s, d_rot_s}),
        .subkey (pc2_s)
    );

`ifdef DES_DECRYPT_EN
    // Mode latch: decrypt is captured together with the key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_r <= 1'b0;
        end else begin
            dec_r <= dec_nxt_s;
        end
    end
`else
    logic unused_decrypt_s;
    assign unused_decrypt_s = decrypt;
    assign dec_r            = 1'b0;
`endif

    // Rotation of C/D for the round currently being computed.
    always_comb begin
        amt_s   = SHIFT_TABLE[round_idx_r];
        c_rot_s = rotl28(c_r, amt_s);
        d_rot_s = rotl28(d_r, amt_s);
`ifdef DES_DECRYPT_EN
        if (dec_r) begin
            // Emission 0 is K16 = PC2(C0,D0); emission r>=1 undoes the
            // shift of round 17-r, i.e. table index 16-r (4-bit wrap of -r).
            if (round_idx_r == 4'd0) begin
                amt_s = 2'd0;
            end else begin
                amt_s = SHIFT_TABLE[4'd0 - round_idx_r];
            end
            c_rot_s = rotr28(c_r, amt_s);
            d_rot_s = rotr28(d_r, amt_s);
        end else begin
            amt_s   = SHIFT_TABLE[round_idx_r];
            c_rot_s = rotl28(c_r, amt_s);
            d_rot_s = rotl28(d_r, amt_s);
        end
`endif
    end

    // Next-state and datapath update for the IDLE/ROUND/HOLD sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        c_nxt_s         = c_r;
        d_nxt_s         = d_r;
        round_idx_nxt_s = round_idx_r;
        subkey_nxt_s    = subkey_r;
        dec_nxt_s       = dec_r;
        case (state_r)
            ST_IDLE: begin
                if (key_valid) begin
                    c_nxt_s         = c_load_s;
                    d_nxt_s         = d_load_s;
                    round_idx_nxt_s = 4'd0;
`ifdef DES_DECRYPT_EN
                    dec_nxt_s       = decrypt;
`endif
                    state_nxt_s     = ST_ROUND;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_ROUND: begin
                c_nxt_s      = c_rot_s;
                d_nxt_s      = d_rot_s;
                subkey_nxt_s = pc2_s;
                state_nxt_s  = ST_HOLD;
            end
            ST_HOLD: begin
                if (subkey_ready) begin
                    if (round_idx_r == LAST_ROUND) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        round_idx_nxt_s = round_idx_r + 4'd1;
                        state_nxt_s     = ST_ROUND;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, C/D halves, round counter and subkey register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            c_r         <= '0;
            d_r         <= '0;
            round_idx_r <= 4'd0;
            subkey_r    <= '0;
        end else begin
            state_r     <= state_nxt_s;
            c_r         <= c_nxt_s;
            d_r         <= d_nxt_s;
            round_idx_r <= round_idx_nxt_s;
            subkey_r    <= subkey_nxt_s;
        end
    end

    // Handshake flags registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_ready_r    <= 1'b1;
            subkey_valid_r <= 1'b0;
            subkey_last_r  <= 1'b0;
        end else begin
            key_ready_r    <= (state_nxt_s == ST_IDLE);
            subkey_valid_r <= (state_nxt_s == ST_HOLD);
            subkey_last_r  <= (state_nxt_s == ST_HOLD) && (round_idx_nxt_s == LAST_ROUND);
        end
    end

    assign key_ready    = key_ready_r;
    assign subkey       = subkey_r;
    assign subkey_valid = subkey_valid_r;
    assign round_idx    = round_idx_r;
    assign subkey_last  = subkey_last_r;

endmodule
